// File: rtl/order_pkg.sv
// ---------------------------------------------------------------------------
// order_pkg -- definitions shared by the order encoder and the order sorter.
//
// Contents:
//   HDR_WRITE / HDR_READ : frame header bytes for write and read orders
//   order_state_t        : frame-builder state enumeration
//   header_byte()        : selects the header byte for an order type
// ---------------------------------------------------------------------------
package order_pkg;

    localparam logic [7:0] HDR_WRITE = 8'h55;
    localparam logic [7:0] HDR_READ  = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LENH = 3'd3,
        ST_LENL = 3'd4,
        ST_DATA = 3'd5,
        ST_CSUM = 3'd6,
        ST_GAP  = 3'd7
    } order_state_t;

    function automatic logic [7:0] header_byte(input logic write);
        return write ? HDR_WRITE : HDR_READ;
    endfunction

endpackage

// File: rtl/order_encoder.sv
// ---------------------------------------------------------------------------
// order_encoder -- turns read/write orders into byte frames for a downstream
// byte FIFO.
//
// Frame layout: header, address, length[15:8], length[7:0], payload (write
// orders with non-zero length only), then an optional XOR checksum byte.
//
// Optional feature: define ORDER_ENCODER_CHECKSUM_EN to append a checksum
// byte (XOR of every preceding byte of the frame). Without the macro the
// CSUM state is unreachable and no checksum byte is produced.
//
// Parameters:
//   GAP_CYCLES  idle cycles (0..255) spent in GAP after each frame before
//               cmd_ready reasserts; 0 returns straight to IDLE.
//
// Ports:
//   clk, rst            single clock; asynchronous active-high reset
//   cmd_valid/cmd_ready order handshake (ready only in IDLE)
//   cmd_write           1 = write order, 0 = read order
//   cmd_address         register address
//   cmd_length          payload byte count (write) / requested count (read)
//   data_valid/ready    payload byte handshake (ready only in DATA)
//   data_in             payload byte
//   fifo_full           downstream FIFO cannot take a byte this cycle
//   fifo_wr_en/fifo_din byte write into the downstream FIFO
//   busy                frame in progress (state other than IDLE)
//   frame_done          one-cycle pulse the cycle after a frame's last byte
//
// Handshake rule: a transfer happens on a rising clock edge where both
// valid and ready are high; valid never waits for ready, and ready may
// depend combinationally on state and fifo_full only.
// ---------------------------------------------------------------------------
module order_encoder
    import order_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_address,
    input  logic [15:0] cmd_length,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [7:0]  data_in,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_din,
    output logic        busy,
    output logic        frame_done
);

    // The gap counter loads GAP_CYCLES-1 on the last frame byte so that
    // GAP lasts exactly GAP_CYCLES cycles (counting down to zero inclusive).
    localparam logic [7:0] GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    order_state_t state;
    order_state_t state_next;

    logic        write_q;
    logic [7:0]  address_q;
    logic [15:0] length_q;
    logic [15:0] remaining_q;
    logic [7:0]  gap_q;
    logic        done_q;

    logic [7:0]  byte_out;
    logic        emit;
    logic        last_byte;
    logic        frame_end;
    logic        accept;

`ifdef ORDER_ENCODER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept = (state == ST_IDLE) && cmd_valid;

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        byte_out   = 8'h00;
        emit       = 1'b0;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        last_byte  = 1'b0;
        frame_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ST_HDR;
                end
            end

            ST_HDR: begin
                byte_out = header_byte(write_q);
                emit     = !fifo_full;
                if (emit) begin
                    state_next = ST_ADDR;
                end
            end

            ST_ADDR: begin
                byte_out = address_q;
                emit     = !fifo_full;
                if (emit) begin
                    state_next = ST_LENH;
                end
            end

            ST_LENH: begin
                byte_out = length_q[15:8];
                emit     = !fifo_full;
                if (emit) begin
                    state_next = ST_LENL;
                end
            end

            ST_LENL: begin
                byte_out = length_q[7:0];
                emit     = !fifo_full;
                if (emit) begin
                    // Reads and zero-length writes carry no payload.
                    if (write_q && (length_q != 16'd0)) begin
                        state_next = ST_DATA;
                    end else begin
                        last_byte = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                // Payload passes straight through; a byte is taken only
                // when the FIFO can absorb it in the same cycle.
                byte_out   = data_in;
                data_ready = !fifo_full;
                emit       = data_valid && !fifo_full;
                if (emit && (remaining_q == 16'd1)) begin
                    last_byte = 1'b1;
                end
            end

            ST_CSUM: begin
`ifdef ORDER_ENCODER_CHECKSUM_EN
                byte_out = csum_q;
                emit     = !fifo_full;
                if (emit) begin
                    frame_end = 1'b1;
                end
`else
                state_next = ST_IDLE;
`endif
            end

            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (last_byte) begin
`ifdef ORDER_ENCODER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            frame_end  = 1'b1;
`endif
        end

        if (frame_end) begin
            state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
    end

    assign fifo_wr_en = emit;
    assign fifo_din   = byte_out;
    assign busy       = (state != ST_IDLE);
    assign frame_done = done_q;

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q     <= 1'b0;
            address_q   <= 8'h00;
            length_q    <= 16'h0000;
            remaining_q <= 16'h0000;
            gap_q       <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            done_q <= frame_end;

            if (accept) begin
                write_q     <= cmd_write;
                address_q   <= cmd_address;
                length_q    <= cmd_length;
                remaining_q <= cmd_length;
            end else if ((state == ST_DATA) && emit) begin
                remaining_q <= remaining_q - 16'd1;
            end

            if (frame_end) begin
                gap_q <= GAP_INIT;
            end else if ((state == ST_GAP) && (gap_q != 8'd0)) begin
                gap_q <= gap_q - 8'd1;
            end
        end
    end

`ifdef ORDER_ENCODER_CHECKSUM_EN
    // Running XOR of every byte written so far in the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            csum_q <= 8'h00;
        end else if (emit && (state != ST_CSUM)) begin
            csum_q <= csum_q ^ byte_out;
        end
    end
`endif

endmodule

// File: tb/tb_order_encoder.sv
// ---------------------------------------------------------------------------
// tb_order_encoder -- self-checking bench for order_encoder (GAP_CYCLES = 3).
// Expected frames are built from the frame layout rules: header byte,
// address, length bytes, payload for writes, optional XOR checksum.
// ---------------------------------------------------------------------------
module tb_order_encoder;

    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_address = 8'h00;
    logic [15:0] cmd_length = 16'h0000;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [7:0]  data_in = 8'h00;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pay_q[$];
    int         got_cyc[$];
    logic       wr_h[$];
    logic [7:0] din_h[$];
    bit         done_seen;
    int         done_cyc;
    int         dready_cnt;
    int         pidx;

    order_encoder #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .busy(busy), .frame_done(frame_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic build_expected(input logic wr, input logic [7:0] a, input logic [15:0] ln);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(wr ? 8'h55 : 8'hAA);
        exp_q.push_back(a);
        exp_q.push_back(ln[15:8]);
        exp_q.push_back(ln[7:0]);
        if (wr) begin
            for (int i = 0; i < int'(ln); i++) exp_q.push_back(pay_q[i]);
        end
`ifdef ORDER_ENCODER_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an order and holds it until accepted (bounded); returns at
    // the first cycle of the frame.
    task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [15:0] ln,
                             output bit acc);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_length  = ln;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                step();
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    // Runs one order to completion; cycle 0 is the first cycle after accept.
    task automatic run_frame(input logic wr, input logic [7:0] a, input logic [15:0] ln,
                             input int full_pct, input int valid_pct,
                             input int stall_lo, input int stall_hi, input int max_cyc);
        bit acc;
        got_q.delete(); got_cyc.delete(); wr_h.delete(); din_h.delete();
        done_seen = 1'b0; done_cyc = -1; dready_cnt = 0; pidx = 0;
        issue_cmd(wr, a, ln, acc);
        if (!acc) return;
        for (int c = 0; c < max_cyc; c++) begin
            fifo_full = (c >= stall_lo && c <= stall_hi) || (int'($urandom_range(99)) < full_pct);
            if (pidx < pay_q.size() && int'($urandom_range(99)) < valid_pct) begin
                data_valid = 1'b1;
                data_in    = pay_q[pidx];
            end else begin
                data_valid = 1'b0;
                data_in    = 8'($urandom_range(255));
            end
            @(negedge clk);
            wr_h.push_back(fifo_wr_en);
            din_h.push_back(fifo_din);
            if (fifo_wr_en) begin
                got_q.push_back(fifo_din);
                got_cyc.push_back(c);
            end
            if (data_ready) dready_cnt++;
            if (data_valid && data_ready) pidx++;
            if (frame_done) begin
                done_seen = 1'b1;
                done_cyc  = c;
            end
            step();
            if (done_seen) break;
        end
        fifo_full  = 1'b0;
        data_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b required 0", fifo_wr_en); end
        n_cmp++; if (fifo_din !== 8'h00) begin n_err++; $display("FAIL reset_din: got %h required 00", fifo_din); end
        n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL reset_data_ready: got %b required 0", data_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL release_cmd_ready: got %b required 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b required 0", busy); end
        step();
    endtask

    task automatic test_write_basic();
        int d;
        int bad;
        pay_q = '{8'hA1, 8'hB2, 8'hC3};
        build_expected(1'b1, 8'h12, 16'd3);
        run_frame(1'b1, 8'h12, 16'd3, 0, 100, -1, -1, 50);
        n_cmp++; if (!done_seen) begin n_err++; $display("FAIL write_done: got no frame_done required pulse"); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL write_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
        bad = 0;
        foreach (got_cyc[i]) if (got_cyc[i] != i) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL write_consecutive: got %0d gaps required 0", bad); end
        n_cmp++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1) begin n_err++; $display("FAIL write_done_timing: got cycle %0d required one after last byte", done_cyc); end
        n_cmp++; if (dready_cnt != 3) begin n_err++; $display("FAIL write_data_ready: got %0d cycles required 3", dready_cnt); end
    endtask

    task automatic test_read();
        int d;
        pay_q = '{8'hEE, 8'hEF};
        build_expected(1'b0, 8'h40, 16'h0100);
        run_frame(1'b0, 8'h40, 16'h0100, 20, 100, -1, -1, 80);
        n_cmp++; if (!done_seen) begin n_err++; $display("FAIL read_done: got no frame_done required pulse"); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL read_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
        n_cmp++; if (dready_cnt != 0 || pidx != 0) begin n_err++; $display("FAIL read_data_ready: got %0d ready cycles %0d consumed required 0 0", dready_cnt, pidx); end
    endtask

    task automatic test_fifo_stall();
        int d;
        int bad;
        pay_q = '{8'($urandom_range(255)), 8'($urandom_range(255))};
        build_expected(1'b1, 8'h12, 16'd2);
        run_frame(1'b1, 8'h12, 16'd2, 0, 100, 1, 5, 60);
        bad = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c >= wr_h.size() || wr_h[c] !== 1'b0 || din_h[c] !== 8'h12) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: got %0d bad stall cycles required 0", bad); end
        n_cmp++; if (got_cyc.size() < 2 || got_cyc[1] != 6) begin n_err++; $display("FAIL stall_resume: got addr at cycle %0d required 6", (got_cyc.size() > 1) ? got_cyc[1] : -1); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL stall_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
    endtask

    task automatic test_len0_and_checksum();
        int d;
        logic [7:0] a;
        a = 8'($urandom_range(255));
        pay_q.delete();
        build_expected(1'b1, a, 16'd0);
        run_frame(1'b1, a, 16'd0, 10, 100, -1, -1, 60);
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL len0_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
        n_cmp++; if (dready_cnt != 0 || !done_seen) begin n_err++; $display("FAIL len0_flow: got ready %0d done %b required 0 1", dready_cnt, done_seen); end
        pay_q = '{8'h0F};
        build_expected(1'b1, 8'h01, 16'd1);
        run_frame(1'b1, 8'h01, 16'd1, 0, 100, -1, -1, 60);
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL len1_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
`ifdef ORDER_ENCODER_CHECKSUM_EN
        n_cmp++; if (got_at(got_q.size() - 1) !== 8'h5A || got_q.size() != 6) begin n_err++; $display("FAIL checksum: got %h (%0d bytes) required 5a (6 bytes)", got_at(got_q.size() - 1), got_q.size()); end
`else
        n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL no_checksum: got %0d bytes required 5", got_q.size()); end
`endif
    endtask

    task automatic test_reset_midframe();
        bit acc;
        int d;
        logic [7:0] a;
        a = 8'($urandom_range(255));
        pay_q.delete();
        repeat (4) pay_q.push_back(8'($urandom_range(255)));
        got_q.delete(); pidx = 0;
        issue_cmd(1'b1, a, 16'd4, acc);
        for (int c = 0; c < 40; c++) begin
            data_valid = (pidx < 4);
            data_in    = (pidx < 4) ? pay_q[pidx] : 8'h00;
            @(negedge clk);
            if (fifo_wr_en) got_q.push_back(fifo_din);
            if (data_valid && data_ready) pidx++;
            if (pidx == 2) break;
            step();
        end
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (fifo_wr_en !== 1'b0 || fifo_din !== 8'h00) begin n_err++; $display("FAIL midreset_fifo: got wr %b din %h required 0 00", fifo_wr_en, fifo_din); end
        n_cmp++; if (busy !== 1'b0 || data_ready !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL midreset_ctrl: got busy %b ready %b done %b required 0 0 0", busy, data_ready, frame_done); end
        data_valid = 1'b0;
        pay_q = pay_q[0:1];
        build_expected(1'b1, a, 16'd4);
        exp_q = exp_q[0:5];
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL midreset_prefix: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
        step();
        rst = 1'b0;
        step();
        pay_q.delete();
        build_expected(1'b0, 8'h77, 16'h0005);
        run_frame(1'b0, 8'h77, 16'h0005, 0, 100, -1, -1, 40);
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL midreset_next: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
    endtask

    task automatic test_back_to_back();
        logic rdy_h[$];
        logic fd_h[$];
        logic [7:0] one[$];
        int acc_n;
        int fd_n;
        int stop_at;
        int f;
        int low;
        int d;
        pay_q.delete();
        build_expected(1'b0, 8'h33, 16'h0010);
        one = exp_q;
        foreach (one[i]) exp_q.push_back(one[i]);
        got_q.delete();
        acc_n = 0; fd_n = 0; stop_at = -1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h33; cmd_length = 16'h0010;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rdy_h.push_back(cmd_ready);
            fd_h.push_back(frame_done);
            if (fifo_wr_en) got_q.push_back(fifo_din);
            if (cmd_ready && cmd_valid) acc_n++;
            if (frame_done) begin
                fd_n++;
                if (fd_n == 2) stop_at = c + GAP + 1;
            end
            step();
            if (acc_n >= 2) cmd_valid = 1'b0;
            if (stop_at >= 0 && c >= stop_at) break;
        end
        cmd_valid = 1'b0;
        f = -1;
        foreach (fd_h[i]) if (fd_h[i] && f < 0) f = i;
        low = 0;
        if (f >= 0) begin
            for (int i = f; i < rdy_h.size(); i++) begin
                if (rdy_h[i] !== 1'b0) break;
                low++;
            end
        end
        n_cmp++; if (low != GAP) begin n_err++; $display("FAIL gap_ready_low: got %0d cycles required %0d", low, GAP); end
        n_cmp++; if (acc_n != 2 || fd_n != 2) begin n_err++; $display("FAIL b2b_count: got %0d accepts %0d done required 2 2", acc_n, fd_n); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_err++; $display("FAIL b2b_bytes: idx %0d got %0d bytes (%h) required %0d bytes (%h)", d, got_q.size(), got_at(d), exp_q.size(), exp_at(d)); end
    endtask

    task automatic test_random();
        int d;
        logic wr;
        logic [7:0] a;
        logic [15:0] ln;
        for (int t = 0; t < 8; t++) begin
            wr = 1'($urandom_range(1));
            a  = 8'($urandom_range(255));
            ln = 16'($urandom_range(10));
            pay_q.delete();
            if (wr) for (int i = 0; i < int'(ln); i++) pay_q.push_back(8'($urandom_range(255)));
            build_expected(wr, a, ln);
            run_frame(wr, a, ln, 30, 70, -1, -1, 400);
            d = first_diff();
            n_cmp++; if (d != -1 || !done_seen) begin n_err++; $display("FAIL random_%0d: idx %0d got %0d bytes (%h) done %b required %0d bytes (%h) done 1", t, d, got_q.size(), got_at(d), done_seen, exp_q.size(), exp_at(d)); end
            n_cmp++; if (pidx != (wr ? int'(ln) : 0)) begin n_err++; $display("FAIL random_consumed_%0d: got %0d required %0d", t, pidx, wr ? int'(ln) : 0); end
        end
    endtask

    task automatic test_max_length();
        int d;
        pay_q.delete();
        for (int i = 0; i < 65535; i++) pay_q.push_back(8'(i * 7 + 3));
        build_expected(1'b1, 8'hFE, 16'hFFFF);
        run_frame(1'b1, 8'hFE, 16'hFFFF, 0, 100, -1, -1, 65600);
        d = first_diff();
        n_cmp++; if (d != -1 || !done_seen) begin n_err++; $display("FAIL maxlen_bytes: idx %0d got %0d bytes (%h) done %b required %0d bytes (%h) done 1", d, got_q.size(), got_at(d), done_seen, exp_q.size(), exp_at(d)); end
        n_cmp++; if (pidx != 65535) begin n_err++; $display("FAIL maxlen_consumed: got %0d required 65535", pidx); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_basic();
        test_read();
        test_fifo_stall();
        test_len0_and_checksum();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_max_length();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/order_encoder.md
ORDER_ENCODER -- requirements
Module: order_encoder

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, meaning idle cycles inserted after each frame before cmd_ready reasserts (0..255).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  order request present.
REQ-005 SHALL have port cmd_ready  output  1  encoder accepts an order.
REQ-006 SHALL have port cmd_write  input  1  1 = write order, 0 = read order.
REQ-007 SHALL have port cmd_address  input  8  register address.
REQ-008 SHALL have port cmd_length  input  16  payload byte count (write) or requested byte count (read).
REQ-009 SHALL have port data_valid  input  1  payload byte present.
REQ-010 SHALL have port data_ready  output  1  payload byte consumed this cycle.
REQ-011 SHALL have port data_in  input  8  payload byte.
REQ-012 SHALL have port fifo_full  input  1  downstream byte FIFO full.
REQ-013 SHALL have port fifo_wr_en  output  1  write strobe to downstream FIFO.
REQ-014 SHALL have port fifo_din  output  8  byte to downstream FIFO.
REQ-015 SHALL have port busy  output  1  frame in progress (any state except IDLE).
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last byte of a frame is written.

Function
REQ-017 SHALL emit frames in the order-sorter byte protocol: header, address, length[15:8], length[7:0], then payload (write orders only), then optional checksum (REQ-030).
REQ-018 SHALL use header HDR_WRITE = 0x55 for write orders and HDR_READ = 0xAA for read orders.
REQ-019 SHALL implement states IDLE, HDR, ADDR, LENH, LENL, DATA, CSUM, GAP.
REQ-020 SHALL assert cmd_ready only in IDLE; on cmd_valid && cmd_ready SHALL latch write flag, address, length and go to HDR next cycle.
REQ-021 SHALL drive fifo_wr_en combinationally as (state in HDR/ADDR/LENH/LENL/CSUM && !fifo_full) or (state == DATA && data_valid && !fifo_full); fifo_din SHALL carry the state's byte in the same cycle.
REQ-022 SHALL advance HDR->ADDR->LENH->LENL only on cycles where fifo_wr_en is high; a full FIFO SHALL stall the state with fifo_din held.
REQ-023 SHALL assert data_ready = (state == DATA && !fifo_full); a byte is consumed only when data_valid && data_ready.
REQ-024 SHALL decrement a 16-bit remaining-count per consumed payload byte and leave DATA after the byte that brings it to 0.
REQ-025 SHALL skip DATA after LENL for read orders and for write orders with length 0.
REQ-026 SHALL enter GAP after the final byte, pulse frame_done for the first cycle after that byte, stay GAP_CYCLES cycles, then return to IDLE; with GAP_CYCLES = 0 SHALL go directly to IDLE.
REQ-027 SHALL accept length 0xFFFF and emit exactly 65535 payload bytes without counter wrap.
REQ-028 SHALL ignore cmd_valid while busy and ignore data_valid outside DATA.

Reset
REQ-029 SHALL on rst, at any time including mid-frame, force IDLE, clear latched order, counter and gap counter; outputs: cmd_ready 1 after release, data_ready 0, fifo_wr_en 0, fifo_din 0x00, busy 0, frame_done 0; a partial frame SHALL NOT be resumed.

Configuration
REQ-030 SHALL, with ORDER_ENCODER_CHECKSUM_EN defined, enter CSUM after the last header/payload byte and emit the XOR of all preceding frame bytes; without it CSUM SHALL be unreachable and no checksum byte emitted.

Structure
REQ-031 SHALL take HDR_WRITE, HDR_READ and the state enumeration from shared package order_pkg, also used by the order sorter.
REQ-032 SHALL be a single module with no sub-modules; the gap counter is 8 bits.

Verification
REQ-033 SHALL cover: write addr 0x12 len 3 data 0xA1,0xB2,0xC3, fifo never full -> bytes 55 12 00 03 A1 B2 C3 on 7 consecutive cycles, frame_done one cycle later.
REQ-034 SHALL cover: read addr 0x40 len 0x0100 -> bytes AA 40 01 00, data_ready never high.
REQ-035 SHALL cover: write len 2, fifo_full held high 5 cycles during ADDR -> fifo_din stays 0x12, no wr_en, then sequence resumes unchanged.
REQ-036 SHALL cover: write len 0 -> 55 addr 00 00 only; with ORDER_ENCODER_CHECKSUM_EN, len 1 data 0x0F addr 0x01 -> checksum byte 0x55^0x01^0x00^0x01^0x0F = 0x5A.
REQ-037 SHALL cover: rst pulsed after 2 payload bytes of a len 4 write -> fifo_wr_en 0 immediately, IDLE, next order starts with header.
REQ-038 SHALL cover: GAP_CYCLES = 3, back-to-back cmd_valid -> cmd_ready low exactly 3 cycles after frame_done cycle.
